// File: rtl/dmem_pkg.sv
// Shared constants for the two-requester data-memory arbiter:
// FSM encoding, RV32I load/store width codes and the latched request record.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic        id;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } xact_t;

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword of a read word and sign- or zero-extends
// it according to the RV32I load width code.
module load_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{addr, 3'b000} +: 8];
    half_sel = addr[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    result = {{16{half_sel[15]}}, half_sel};
      F3_BU:   result = {24'b0, byte_sel};
      F3_HU:   result = {16'b0, half_sel};
      F3_W:    result = word;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data memory between a CPU (r0) and a DMA (r1);
// each access takes three cycles: grant, memory access, response.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_req,
  input  logic        r0_we,
  input  logic [2:0]  r0_funct3,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  output logic        r0_gnt,
  output logic        r0_rvalid,
  output logic [31:0] r0_rdata,
  output logic        r0_err,
  input  logic        r1_req,
  input  logic        r1_we,
  input  logic [2:0]  r1_funct3,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  output logic        r1_gnt,
  output logic        r1_rvalid,
  output logic [31:0] r1_rdata,
  output logic        r1_err,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [2:0]  mem_funct3,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writeData,
  input  logic [31:0] mem_readData
);

  state_t      state, next_state;
  logic        ptr;        // 1 = r1 wins a tie
  xact_t       cur;
  logic [31:0] rdata_q;
  logic [31:0] aligned;
  logic        any_req, win1, fault, misalign, out_of_range, bad_code;
  xact_t       sel;

  assign any_req = r0_req | r1_req;
  assign win1    = r1_req & (~r0_req | ptr);

  always_comb begin
    if (win1) sel = '{id: 1'b1, we: r1_we, funct3: r1_funct3, addr: r1_addr, wdata: r1_wdata};
    else      sel = '{id: 1'b0, we: r0_we, funct3: r0_funct3, addr: r0_addr, wdata: r0_wdata};
  end

  always_comb begin
    misalign     = ((cur.funct3 == F3_W) && (cur.addr[1:0] != 2'b00)) ||
                   (((cur.funct3 == F3_H) || (cur.funct3 == F3_HU)) && cur.addr[0]);
    out_of_range = {2'b00, cur.addr[31:2]} >= NUM_WORDS;
    if (cur.we) bad_code = !(cur.funct3 inside {F3_B, F3_H, F3_W});
    else        bad_code = !(cur.funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    fault = misalign | out_of_range | bad_code;
  end

  load_align u_align (
    .funct3 (cur.funct3),
    .addr   (cur.addr[1:0]),
    .word   (rdata_q),
    .result (aligned)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_req) next_state = ACCESS;
      ACCESS:  next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr     <= 1'b0;
      cur     <= '0;
      rdata_q <= '0;
    end else begin
      if ((state == IDLE) && any_req) begin
        cur <= sel;
        ptr <= ~win1;
      end
      if (state == ACCESS) rdata_q <= mem_readData;
    end
  end

  always_comb begin
    r0_gnt        = 1'b0;
    r1_gnt        = 1'b0;
    r0_rvalid     = 1'b0;
    r1_rvalid     = 1'b0;
    r0_err        = 1'b0;
    r1_err        = 1'b0;
    r0_rdata      = '0;
    r1_rdata      = '0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    mem_funct3    = '0;
    mem_address   = '0;
    mem_writeData = '0;
    case (state)
      IDLE: begin
        // Grant is combinational on req, so reset must mask it explicitly.
        r0_gnt = ~rst & any_req & ~win1;
        r1_gnt = ~rst & win1;
      end
      ACCESS: begin
        MemRead       = ~cur.we & ~fault;
        MemWrite      = cur.we & ~fault;
        mem_funct3    = cur.funct3;
        mem_address   = cur.addr;
        mem_writeData = cur.wdata;
      end
      RESP: begin
        if (cur.id) begin
          r1_rvalid = 1'b1;
          r1_err    = fault;
          r1_rdata  = (cur.we | fault) ? '0 : aligned;
        end else begin
          r0_rvalid = 1'b1;
          r0_err    = fault;
          r0_rdata  = (cur.we | fault) ? '0 : aligned;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a transaction-level schedule model checked
// every cycle, plus literal expectations for the key load/store scenarios.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        r0_req = 0, r0_we = 0, r1_req = 0, r1_we = 0;
  logic [2:0]  r0_funct3 = 0, r1_funct3 = 0;
  logic [31:0] r0_addr = 0, r0_wdata = 0, r1_addr = 0, r1_wdata = 0;
  logic        r0_gnt, r0_rvalid, r0_err, r1_gnt, r1_rvalid, r1_err;
  logic [31:0] r0_rdata, r1_rdata;
  logic        MemRead, MemWrite;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_address, mem_writeData, mem_readData;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] dev_mem [64];
  logic [31:0] ref_mem [64];

  always #5 clk = ~clk;

  dmem_arbiter #(.NUM_WORDS(64)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_funct3(r0_funct3), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_req(r1_req), .r1_we(r1_we), .r1_funct3(r1_funct3), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata), .r1_err(r1_err),
    .MemRead(MemRead), .MemWrite(MemWrite), .mem_funct3(mem_funct3),
    .mem_address(mem_address), .mem_writeData(mem_writeData), .mem_readData(mem_readData)
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic int unsigned size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic logic model_fault(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    int unsigned sz = size_of(f3);
    if ((addr >> 2) >= 64) return 1'b1;
    if (sz == 0) return 1'b1;
    if (we && f3[2]) return 1'b1;
    if ((addr % sz) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] word);
    int unsigned sz = size_of(f3);
    logic [31:0] v = word >> (8 * (addr % 4));
    if (sz == 1) begin
      v = v & 32'hFF;
      if (!f3[2] && v >= 128) v = v + 32'hFFFFFF00;
    end else if (sz == 2) begin
      v = v & 32'hFFFF;
      if (!f3[2] && v >= 32768) v = v + 32'hFFFF0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] merge_store(input logic [31:0] old, input logic [2:0] f3,
                                              input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] res = old;
    int unsigned sz = size_of(f3);
    for (int unsigned k = 0; k < sz; k++) res[8*((addr % 4) + k) +: 8] = wd[8*k +: 8];
    return res;
  endfunction

  // Memory device seen by the arbiter.
  assign mem_readData = (mem_address[31:2] < 64) ? dev_mem[mem_address[7:2]] : 32'h0;
  always @(posedge clk)
    if (MemWrite && mem_address[31:2] < 64)
      dev_mem[mem_address[7:2]] <= merge_store(dev_mem[mem_address[7:2]], mem_funct3, mem_address, mem_writeData);

  // Schedule model: a grant at cycle g occupies g..g+2, memory at g+1, response at g+2.
  int          cyc = 0;
  int          free_at = 0;
  logic        m_ptr = 0;
  logic        p_valid = 0;
  int          p_gnt = 0;
  logic        p_id, p_we, p_fault;
  logic [2:0]  p_f3;
  logic [31:0] p_addr, p_wd, p_rd;
  logic        e_gnt [2], e_rv [2], e_err [2];
  logic [31:0] e_rdat [2];
  logic        e_mr, e_mw, w;
  logic [2:0]  e_f3;
  logic [31:0] e_ad, e_wd;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      e_gnt[i] = 0; e_rv[i] = 0; e_err[i] = 0; e_rdat[i] = 0;
    end
    e_mr = 0; e_mw = 0; e_f3 = 0; e_ad = 0; e_wd = 0;
    if (rst) begin
      p_valid = 0; m_ptr = 0; free_at = cyc + 1;
    end else begin
      if (p_valid && cyc == p_gnt + 1) begin
        e_mr = !p_we && !p_fault; e_mw = p_we && !p_fault;
        e_f3 = p_f3; e_ad = p_addr; e_wd = p_wd;
      end
      if (p_valid && cyc == p_gnt + 2) begin
        e_rv[p_id] = 1; e_err[p_id] = p_fault; e_rdat[p_id] = p_rd; p_valid = 0;
      end
      if (cyc >= free_at && (r0_req || r1_req)) begin
        w = (r0_req && r1_req) ? m_ptr : r1_req;
        e_gnt[w] = 1; m_ptr = !w;
        p_id = w; p_we = w ? r1_we : r0_we; p_f3 = w ? r1_funct3 : r0_funct3;
        p_addr = w ? r1_addr : r0_addr; p_wd = w ? r1_wdata : r0_wdata;
        p_fault = model_fault(p_we, p_f3, p_addr);
        p_rd = 0;
        if (!p_fault && !p_we) p_rd = model_load(p_f3, p_addr, ref_mem[p_addr[7:2]]);
        if (!p_fault && p_we) ref_mem[p_addr[7:2]] = merge_store(ref_mem[p_addr[7:2]], p_f3, p_addr, p_wd);
        p_gnt = cyc; p_valid = 1; free_at = cyc + 3;
      end
    end
    check("r0_gnt", r0_gnt, e_gnt[0]);       check("r1_gnt", r1_gnt, e_gnt[1]);
    check("r0_rvalid", r0_rvalid, e_rv[0]);  check("r1_rvalid", r1_rvalid, e_rv[1]);
    check("r0_err", r0_err, e_err[0]);       check("r1_err", r1_err, e_err[1]);
    check("r0_rdata", r0_rdata, e_rdat[0]);  check("r1_rdata", r1_rdata, e_rdat[1]);
    check("MemRead", MemRead, e_mr);         check("MemWrite", MemWrite, e_mw);
    check("mem_funct3", mem_funct3, e_f3);   check("mem_address", mem_address, e_ad);
    check("mem_writeData", mem_writeData, e_wd);
    cyc++;
  end

  task automatic drive(input logic id, input logic req, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (id) begin r1_req = req; r1_we = we; r1_funct3 = f3; r1_addr = addr; r1_wdata = wd; end
    else    begin r0_req = req; r0_we = we; r0_funct3 = f3; r0_addr = addr; r0_wdata = wd; end
  endtask

  task automatic do_access(input logic id, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                           input string name);
    logic got = 0;
    logic [31:0] rd = 0;
    logic er = 0;
    @(posedge clk); #1;
    drive(id, 1'b1, we, f3, addr, wd);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (id ? r1_gnt : r0_gnt) begin got = 1; break; end
    end
    check({name, "_granted"}, got, 1);
    @(posedge clk); #1;
    drive(id, 1'b0, we, f3, addr, wd);
    got = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (id ? r1_rvalid : r0_rvalid) begin
        got = 1; rd = id ? r1_rdata : r0_rdata; er = id ? r1_err : r0_err; break;
      end
    end
    check({name, "_responded"}, got, 1);
    if (got) begin
      check({name, "_rdata"}, rd, exp_rd);
      check({name, "_err"}, er, exp_err);
    end
  endtask

  int gid [12];

  initial begin
    for (int i = 0; i < 64; i++) begin dev_mem[i] = 0; ref_mem[i] = 0; end
    repeat (3) @(posedge clk);
    #1 rst = 0;

    do_access(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        0, "sw_10");
    do_access(0, 0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 0, "lw_10");
    do_access(0, 0, 3'b000, 32'h13, 32'h0,        32'hFFFFFFDE, 0, "lb_13");
    do_access(0, 0, 3'b100, 32'h13, 32'h0,        32'h000000DE, 0, "lbu_13");
    do_access(0, 0, 3'b001, 32'h12, 32'h0,        32'hFFFFDEAD, 0, "lh_12");
    do_access(0, 0, 3'b101, 32'h10, 32'h0,        32'h0000BEEF, 0, "lhu_10");
    do_access(1, 1, 3'b010, 32'h02, 32'h11111111, 32'h0,        1, "sw_misalign");
    do_access(1, 0, 3'b001, 32'h11, 32'h0,        32'h0,        1, "lh_misalign");
    do_access(1, 0, 3'b010, 32'h100, 32'h0,       32'h0,        1, "lw_range");
    do_access(1, 1, 3'b100, 32'h04, 32'h0,        32'h0,        1, "store_badcode");

    // Round-robin from reset with both ports requesting continuously.
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    drive(0, 1, 0, 3'b010, 32'h10, 0);
    drive(1, 1, 0, 3'b010, 32'h14, 0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      gid[k] = r0_gnt ? 0 : (r1_gnt ? 1 : -1);
    end
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    for (int j = 0; j < 4; j++) check($sformatf("rr_grant_%0d", j), gid[3*j], j % 2);
    check("rr_gap", gid[1], -1);

    // Reset during the ACCESS cycle of a store.
    @(posedge clk); #1;
    drive(1, 1, 1, 3'b010, 32'h20, 32'h12345678);
    begin
      logic got = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (r1_gnt) begin got = 1; break; end
      end
      check("rst_store_granted", got, 1);
    end
    @(posedge clk); #1;
    drive(1, 0, 0, 0, 0, 0);
    rst = 1;
    @(negedge clk);
    check("rst_memwrite_dropped", MemWrite, 0);
    @(posedge clk); #1 rst = 0;
    drive(0, 1, 0, 3'b010, 32'h10, 0);
    drive(1, 1, 0, 3'b010, 32'h14, 0);
    @(negedge clk);
    check("post_rst_r0_gnt", r0_gnt, 1);
    check("post_rst_r1_gnt", r1_gnt, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    repeat (4) @(posedge clk);
    check("word_20_unchanged", dev_mem[8], 32'h0);
    check("word_10_value", dev_mem[4], 32'hDEADBEEF);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
